// File: rtl/fractal_engine.sv
// ============================================================================
// fractal_engine -- one-point Mandelbrot/Julia escape-time iterator
// Revision: 1.0
// ============================================================================
`default_nettype none

module fractal_engine #(
    parameter int FP_BITS = 32,
    parameter int FP_FRAC = 24,
    parameter int ITER_W  = 16,
    parameter int PIX_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      mode,
    input  logic signed [FP_BITS-1:0] julia_cr,
    input  logic signed [FP_BITS-1:0] julia_ci,
    input  logic [ITER_W-1:0]         iter_max,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [FP_BITS-1:0] in_x0,
    input  logic signed [FP_BITS-1:0] in_y0,
    input  logic [PIX_W-1:0]          in_xpix,
    input  logic [PIX_W-1:0]          in_ypix,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ITER_W-1:0]         out_iter,
    output logic                      out_escaped,
    output logic [PIX_W-1:0]          out_xpix,
    output logic [PIX_W-1:0]          out_ypix
);

    localparam int PW = 2 * FP_BITS;
    localparam logic [PW:0] ONE_WIDE = 1;
    localparam logic [PW:0] ESC_LIM  = ONE_WIDE << (2 * FP_FRAC + 2);

    generate
        if (FP_BITS - FP_FRAC < 4) begin : g_int_bits_check
            $error("fractal_engine: FP_BITS-FP_FRAC must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [FP_BITS-1:0] zx, zy, cx, cy;
    logic [ITER_W-1:0]         count, iter_lim;

    logic signed [PW-1:0] zx_w, zy_w, xx, yy, xy;
    logic [PW:0]          mag;
    logic signed [PW:0]   diff, xy2;
    logic signed [FP_BITS-1:0] x_next, y_next;
    logic escape, at_cap, accept;

    // Full-width squares: the sum needs one extra bit so it can never wrap.
    assign zx_w   = {{FP_BITS{zx[FP_BITS-1]}}, zx};
    assign zy_w   = {{FP_BITS{zy[FP_BITS-1]}}, zy};
    assign xx     = zx_w * zx_w;
    assign yy     = zy_w * zy_w;
    assign xy     = zx_w * zy_w;
    assign mag    = {1'b0, xx} + {1'b0, yy};
    assign diff   = {xx[PW-1], xx} - {yy[PW-1], yy};
    assign xy2    = {xy, 1'b0};
    assign x_next = FP_BITS'(diff >>> FP_FRAC) + cx;
    assign y_next = FP_BITS'(xy2 >>> FP_FRAC) + cy;
    assign escape = (mag >= ESC_LIM);
    assign at_cap = (count == iter_lim);

    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = ((state == IDLE) || ((state == DONE) && out_ready)) && !flush;
        accept    = in_valid && in_ready;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (escape || at_cap) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zx          <= '0;
            zy          <= '0;
            cx          <= '0;
            cy          <= '0;
            count       <= '0;
            iter_lim    <= '0;
            out_iter    <= '0;
            out_escaped <= 1'b0;
            out_xpix    <= '0;
            out_ypix    <= '0;
        end else if (accept) begin
            out_xpix <= in_xpix;
            out_ypix <= in_ypix;
            iter_lim <= iter_max;
            count    <= '0;
            if (mode) begin
                zx <= in_x0;
                zy <= in_y0;
                cx <= julia_cr;
                cy <= julia_ci;
            end else begin
                zx <= '0;
                zy <= '0;
                cx <= in_x0;
                cy <= in_y0;
            end
        end else if ((state == CALC) && !flush) begin
            // Escape wins over the cap when both hold in the same cycle.
            if (escape || at_cap) begin
                out_iter    <= count;
                out_escaped <= escape;
            end else begin
                zx    <= x_next;
                zy    <= y_next;
                count <= count + ITER_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fractal_engine.sv
// ============================================================================
// tb_fractal_engine -- directed and random checks against an iteration model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fractal_engine;

    logic               clk;
    logic               reset_n;
    logic               flush;
    logic               mode;
    logic signed [31:0] julia_cr, julia_ci;
    logic [15:0]        iter_max;
    logic               in_valid, in_ready;
    logic signed [31:0] in_x0, in_y0;
    logic [15:0]        in_xpix, in_ypix;
    logic               out_valid, out_ready;
    logic [15:0]        out_iter;
    logic               out_escaped;
    logic [15:0]        out_xpix, out_ypix;

    int checks = 0;
    int errors = 0;

    fractal_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .mode       (mode),
        .julia_cr   (julia_cr),
        .julia_ci   (julia_ci),
        .iter_max   (iter_max),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x0      (in_x0),
        .in_y0      (in_y0),
        .in_xpix    (in_xpix),
        .in_ypix    (in_ypix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_iter   (out_iter),
        .out_escaped(out_escaped),
        .out_xpix   (out_xpix),
        .out_ypix   (out_ypix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Escape-time iteration in plain wide integer arithmetic.
    function automatic void ref_model(input logic signed [31:0] zx0, input logic signed [31:0] zy0,
                                      input logic signed [31:0] cr, input logic signed [31:0] ci,
                                      input logic [15:0] imax,
                                      output logic [15:0] it, output logic esc);
        logic signed [65:0] x, y, xx, yy, xy;
        logic signed [31:0] nx, ny;
        x = zx0;
        y = zy0;
        it = 16'd0;
        esc = 1'b0;
        for (int n = 0; n <= int'(imax); n++) begin
            xx = x * x;
            yy = y * y;
            xy = x * y;
            if (xx + yy >= (66'sd4 <<< 48)) begin
                it = 16'(n);
                esc = 1'b1;
                return;
            end
            if (n == int'(imax)) begin
                it = 16'(n);
                esc = 1'b0;
                return;
            end
            nx = 32'((xx - yy) >>> 24) + cr;
            ny = 32'((2 * xy) >>> 24) + ci;
            x = nx;
            y = ny;
        end
    endfunction

    task automatic run_job(input string tag, input logic m,
                           input logic signed [31:0] x0, input logic signed [31:0] y0,
                           input logic signed [31:0] jr, input logic signed [31:0] ji,
                           input logic [15:0] im, input int hold);
        logic [15:0] eit, xp, yp;
        logic        eesc;
        int          k;
        if (m) ref_model(x0, y0, jr, ji, im, eit, eesc);
        else   ref_model(32'sd0, 32'sd0, x0, y0, im, eit, eesc);
        xp = 16'($urandom);
        yp = 16'($urandom);
        mode = m; julia_cr = jr; julia_ci = ji; in_x0 = x0; in_y0 = y0;
        in_xpix = xp; in_ypix = yp; iter_max = im; in_valid = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 50) begin tick(); k++; end
        check({tag, "/in_ready"}, in_ready, 1);
        tick();
        // Scramble the job inputs: the running job must not see them.
        in_valid = 1'b0; mode = ~m; julia_cr = $urandom; julia_ci = $urandom;
        iter_max = 16'($urandom); in_x0 = $urandom; in_y0 = $urandom;
        k = 1;
        while (!out_valid && k < int'(im) + 8) begin tick(); k++; end
        check({tag, "/latency"}, 64'(k), 64'(int'(eit) + 2));
        check({tag, "/iter"}, out_iter, eit);
        check({tag, "/escaped"}, out_escaped, eesc);
        check({tag, "/xpix"}, out_xpix, xp);
        check({tag, "/ypix"}, out_ypix, yp);
        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) tick();
            check({tag, "/hold_valid"}, out_valid, 1);
            check({tag, "/hold_iter"}, out_iter, eit);
            check({tag, "/hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/released"}, out_valid, 0);
    endtask

    initial begin
        logic [15:0] eit_a, eit_b, xp_a, it_snap;
        logic        eesc_a, eesc_b;
        int          k, seen;
        logic        rm;
        logic signed [31:0] rx, ry, rjr, rji;

        reset_n = 1'b0; flush = 1'b0; mode = 1'b0; julia_cr = '0; julia_ci = '0;
        iter_max = '0; in_valid = 1'b0; in_x0 = '0; in_y0 = '0; in_xpix = '0;
        in_ypix = '0; out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst/out_valid", out_valid, 0);
        check("rst/out_iter", out_iter, 0);
        check("rst/out_escaped", out_escaped, 0);
        check("rst/out_xpix", out_xpix, 0);
        check("rst/out_ypix", out_ypix, 0);
        reset_n = 1'b1;
        #1;
        check("rst/first_in_ready", in_ready, 1);

        // Directed scenarios
        run_job("mb_origin_cap10", 1'b0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 16'd10, 0);
        run_job("mb_c2p5", 1'b0, 32'sd41943040, 32'sd0, 32'sd0, 32'sd0, 16'd20, 0);
        run_job("julia_z3", 1'b1, 32'sd50331648, 32'sd0, 32'sd0, 32'sd0, 16'd20, 0);
        run_job("julia_cap0", 1'b1, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 16'd0, 0);
        run_job("julia_esc_at_cap", 1'b1, 32'sd50331648, 32'sd0, 32'sd0, 32'sd0, 16'd0, 0);
        run_job("julia_quarter", 1'b1, 32'sd4194304, -32'sd8388608, -32'sd13421773, 32'sd2516582, 16'd40, 2);

        // Back-to-back with 5 cycles of output backpressure
        ref_model(32'sd0, 32'sd0, 32'sd4194304, 32'sd0, 16'd5, eit_a, eesc_a);
        ref_model(32'sd0, 32'sd0, 32'sd41943040, 32'sd0, 16'd9, eit_b, eesc_b);
        mode = 1'b0; in_x0 = 32'sd4194304; in_y0 = 32'sd0; iter_max = 16'd5;
        in_xpix = 16'h1111; in_ypix = 16'h2222; in_valid = 1'b1;
        #1;
        check("b2b/a_ready", in_ready, 1);
        tick();
        in_x0 = 32'sd41943040; iter_max = 16'd9; in_xpix = 16'h3333; in_ypix = 16'h4444;
        k = 1;
        while (!out_valid && k < 20) begin tick(); k++; end
        check("b2b/a_valid", out_valid, 1);
        check("b2b/a_iter", out_iter, eit_a);
        it_snap = out_iter;
        xp_a = out_xpix;
        seen = 0;
        repeat (5) begin
            tick();
            if (!out_valid || out_iter !== it_snap || out_xpix !== xp_a || in_ready) seen++;
        end
        check("b2b/hold_stable", 64'(seen), 0);
        out_ready = 1'b1;
        #1;
        check("b2b/same_cycle_ready", in_ready, 1);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check("b2b/in_calc", out_valid, 0);
        k = 1;
        while (!out_valid && k < 20) begin tick(); k++; end
        check("b2b/b_latency", 64'(k), 64'(int'(eit_b) + 2));
        check("b2b/b_iter", out_iter, eit_b);
        check("b2b/b_escaped", out_escaped, eesc_b);
        check("b2b/b_xpix", out_xpix, 16'h3333);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush on the 3rd CALC cycle, with a competing in_valid
        mode = 1'b0; in_x0 = 32'sd0; in_y0 = 32'sd0; iter_max = 16'd20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("flush/in_ready_low", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("flush/out_valid", out_valid, 0);
        check("flush/idle_ready", in_ready, 1);
        seen = 0;
        repeat (30) begin tick(); if (out_valid) seen++; end
        check("flush/no_result", 64'(seen), 0);

        // Flush while DONE beats out_ready and in_valid
        mode = 1'b1; in_x0 = 32'sd50331648; in_y0 = 32'sd0; julia_cr = '0; julia_ci = '0;
        iter_max = 16'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("flush_done/valid", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        check("flush_done/in_ready", in_ready, 0);
        tick();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        seen = 0;
        repeat (10) begin if (out_valid) seen++; tick(); end
        check("flush_done/dropped", 64'(seen), 0);

        // Asynchronous reset in the middle of CALC
        run_job("pre_reset", 1'b0, 32'sd4194304, 32'sd4194304, 32'sd0, 32'sd0, 16'd7, 0);
        mode = 1'b0; in_x0 = 32'sd0; in_y0 = 32'sd0; iter_max = 16'd20;
        in_xpix = 16'hABCD; in_ypix = 16'h1234; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst/out_valid", out_valid, 0);
        check("arst/out_iter", out_iter, 0);
        check("arst/out_xpix", out_xpix, 0);
        check("arst/out_ypix", out_ypix, 0);
        tick();
        reset_n = 1'b1;
        #1;
        check("arst/in_ready", in_ready, 1);
        seen = 0;
        repeat (25) begin tick(); if (out_valid) seen++; end
        check("arst/no_result", 64'(seen), 0);

        // Randomized jobs
        for (int j = 0; j < 40; j++) begin
            rm  = 1'(j % 2);
            rx  = $signed(32'($urandom_range(83886080))) - 32'sd41943040;
            ry  = $signed(32'($urandom_range(83886080))) - 32'sd41943040;
            rjr = $signed(32'($urandom_range(67108864))) - 32'sd33554432;
            rji = $signed(32'($urandom_range(67108864))) - 32'sd33554432;
            if (j % 8 == 7) rx = $urandom;
            run_job($sformatf("rand%0d", j), rm, rx, ry, rjr, rji,
                    16'($urandom_range(30)), int'($urandom_range(3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
